// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } md_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Widest operand the sequencer is expected to be built with; the
  // divide-by-zero quotient is sliced from this constant.
  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide loop on a (2*WIDTH+1)-bit accumulator.
// MULT: accumulator = {partial[WIDTH:0], multiplier[WIDTH-1:0]} (shift-add, shift right).
// DIV:  accumulator = {remainder[WIDTH:0], dividend/quotient[WIDTH-1:0]} (restoring, shift left).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_in,
  input  logic [WIDTH:0]   opnd,
  input  logic             op_div,
  output logic [2*WIDTH:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] diff;

  // Compute the next accumulator for a single shift-add or restoring-divide step
  always_comb begin
    sum     = acc_in[2*WIDTH:WIDTH] + opnd;
    sh      = {acc_in[2*WIDTH-1:0], 1'b0};
    diff    = {1'b0, sh[2*WIDTH:WIDTH]} - {1'b0, opnd};
    acc_out = acc_in;
    if (op_div == OP_DIV) begin
      if (diff[WIDTH+1]) begin
        acc_out = sh;
      end else begin
        acc_out = {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
      end
    end else begin
      if (acc_in[0]) begin
        acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
      end else begin
        acc_out = {1'b0, acc_in[2*WIDTH:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV engine owning the HI/LO pair, with pipeline interlock.
// Operands are reduced to unsigned magnitudes at issue; signs are applied in FINISH.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH:0]     opnd;
  logic               op_q;
  logic               sign_a;
  logic               sign_b;
  logic               dz_q;

  logic [WIDTH:0]     ext_a, ext_b;
  logic [WIDTH:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign ext_a = {src_a[WIDTH-1], src_a};
  assign ext_b = {src_b[WIDTH-1], src_b};
  assign mag_a = src_a[WIDTH-1] ? -ext_a : ext_a;
  assign mag_b = src_b[WIDTH-1] ? -ext_b : ext_b;

  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);
  assign stall = busy & (start | rd_hilo);

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_in (acc),
    .opnd   (opnd),
    .op_div (op_q),
    .acc_out(acc_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: accept only from IDLE, run WIDTH iterations, one FINISH cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sign correction of the magnitude result; divide-by-zero forces LO to all ones
  always_comb begin
    prod     = acc[2*WIDTH-1:0];
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (op_q == OP_DIV) begin
      fin_hi = sign_a ? -rem : rem;
      fin_lo = (sign_a ^ sign_b) ? -quo : quo;
      if (dz_q) begin
        fin_lo = DIV_ZERO_LO[WIDTH-1:0];
      end
    end
  end

  // Datapath: latch operands on issue, iterate in RUN, commit HI/LO in FINISH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= OP_MULT;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op_div;
            sign_a   <= src_a[WIDTH-1];
            sign_b   <= src_b[WIDTH-1];
            dz_q     <= (op_div == OP_DIV) && (src_b == '0);
            cnt      <= CNT_W'(WIDTH - 1);
            opnd     <= (op_div == OP_DIV) ? mag_b : mag_a;
            acc      <= {{(WIDTH+1){1'b0}},
                         (op_div == OP_DIV) ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0]};
            div_zero <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_step;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FINISH: begin
          hi <= fin_hi;
          lo <= fin_lo;
          if (op_q == OP_DIV) begin
            div_zero <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed spec cases, interlock,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_div;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         rd_hilo;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_h = '0;
  logic [W-1:0] prev_l = '0;

  muldiv_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_div  (op_div),
    .src_a   (src_a),
    .src_b   (src_b),
    .rd_hilo (rd_hilo),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Reference: signed 64-bit arithmetic, truncating division, remainder follows dividend
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic div,
                                output logic [W-1:0] eh, output logic [W-1:0] el,
                                output logic edz);
    longint sa, sb, r, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0;
    if (!div) begin
      r  = sa * sb;
      eh = r[63:32];
      el = r[31:0];
    end else if (b == '0) begin
      eh  = a;
      el  = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  function automatic logic [35:0] window(input int first, input int last);
    logic [35:0] m = '0;
    for (int k = first; k <= last; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Issue one op at edge 0 and record busy/done per cycle 1..34 plus HI/LO snapshots
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic div,
                        output logic [35:0] bt, output logic [35:0] dt,
                        output logic [W-1:0] h33, output logic [W-1:0] l33,
                        output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic dz1, output logic dz);
    src_a  = a;
    src_b  = b;
    op_div = div;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bt  = '0;
    dt  = '0;
    h33 = '0;
    l33 = '0;
    dz1 = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      bt[k] = busy;
      dt[k] = done;
      if (k == 1) dz1 = div_zero;
      if (k == 33) begin
        h33 = hi;
        l33 = lo;
      end
    end
    h  = hi;
    l  = lo;
    dz = div_zero;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    op_div  = 1'b0;
    src_a   = '0;
    src_b   = '0;
    rd_hilo = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero, stall} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/dz/stall=%b expected 0000",
               {busy, done, div_zero, stall});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got hi=%h lo=%h expected 0", hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEF,
                             32'h8000_0000, 32'd100, 32'd3};
    logic [W-1:0] tb [7] = '{32'd6, 32'd5, 32'hFFFF_FFFF, 32'd5,
                             32'hFFFF_FFFF, 32'd0, 32'd4};
    logic         td [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] eh [7] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE,
                             32'h0, 32'd100, 32'h0};
    logic [W-1:0] el [7] = '{32'h2A, 32'hFFFF_FFF1, 32'h1, 32'hFFFF_FFFD,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'hC};
    logic         ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [35:0] bt, dt;
    logic [W-1:0] h33, l33, h, l;
    logic dz1, dz;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], td[i], bt, dt, h33, l33, h, l, dz1, dz);
      checks++;
      if (bt !== window(1, 33)) begin
        errors++;
        $display("FAIL dir_busy case %0d: got %b expected %b", i, bt, window(1, 33));
      end
      checks++;
      if (dt !== window(33, 33)) begin
        errors++;
        $display("FAIL dir_done case %0d: got %b expected %b", i, dt, window(33, 33));
      end
      checks++;
      if ({h33, l33} !== {prev_h, prev_l}) begin
        errors++;
        $display("FAIL dir_hold case %0d: got %h/%h expected %h/%h", i, h33, l33, prev_h, prev_l);
      end
      checks++;
      if (dz1 !== 1'b0) begin
        errors++;
        $display("FAIL dir_dz_clear case %0d: got %b expected 0", i, dz1);
      end
      checks++;
      if ({h, l, dz} !== {eh[i], el[i], ez[i]}) begin
        errors++;
        $display("FAIL dir_result case %0d: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                 i, h, l, dz, eh[i], el[i], ez[i]);
      end
      prev_h = eh[i];
      prev_l = el[i];
    end
  endtask

  task automatic test_interlock();
    logic [W-1:0] eh, el;
    logic edz;
    logic [35:0] bt = '0, dt = '0;
    int extra = 0;
    model(32'd12345, 32'hFFFF_FFF9, 1'b0, eh, el, edz);
    src_a  = 32'd12345;
    src_b  = 32'hFFFF_FFF9;
    op_div = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      bt[k] = busy;
      dt[k] = done;
      if (k == 5) begin
        rd_hilo = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
          errors++;
          $display("FAIL stall_rd_hilo: got %b expected 1", stall);
        end
        checks++;
        if ({hi, lo} !== {prev_h, prev_l}) begin
          errors++;
          $display("FAIL hold_rd_hilo: got %h/%h expected %h/%h", hi, lo, prev_h, prev_l);
        end
      end
      if (k == 6) begin
        rd_hilo = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL stall_idle_req: got %b expected 0", stall);
        end
      end
      if (k == 10) begin
        src_a  = 32'd99;
        src_b  = 32'd2;
        op_div = 1'b1;
        start  = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
          errors++;
          $display("FAIL stall_start: got %b expected 1", stall);
        end
      end
      if (k == 11) start = 1'b0;
      if (k == 34) begin
        rd_hilo = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL stall_after_done: got %b expected 0", stall);
        end
        checks++;
        if ({hi, lo} !== {eh, el}) begin
          errors++;
          $display("FAIL interlock_result: got %h/%h expected %h/%h", hi, lo, eh, el);
        end
        rd_hilo = 1'b0;
      end
    end
    checks++;
    if (bt !== window(1, 33) || dt !== window(33, 33)) begin
      errors++;
      $display("FAIL interlock_timing: busy %b done %b expected busy %b done %b",
               bt, dt, window(1, 33), window(33, 33));
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_start: got %0d busy/done cycles expected 0", extra);
    end
    prev_h = eh;
    prev_l = el;
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] eh, el, h33, l33, h, l;
    logic edz, dz1, dz;
    logic [35:0] bt, dt;
    int extra = 0;
    src_a  = 32'd1000;
    src_b  = 32'd7;
    op_div = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL midop_reset_flags: got busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL midop_reset_hilo: got %h/%h expected 0/0", hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done || hi != '0 || lo != '0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL midop_no_resume: got %0d active cycles expected 0", extra);
    end
    model(32'd1000, 32'd7, 1'b1, eh, el, edz);
    run_op(32'd1000, 32'd7, 1'b1, bt, dt, h33, l33, h, l, dz1, dz);
    checks++;
    if (bt !== window(1, 33) || dt !== window(33, 33)) begin
      errors++;
      $display("FAIL post_reset_timing: busy %b done %b", bt, dt);
    end
    checks++;
    if ({h, l, dz} !== {eh, el, edz}) begin
      errors++;
      $display("FAIL post_reset_result: got %h/%h/%b expected %h/%h/%b", h, l, dz, eh, el, edz);
    end
    prev_h = eh;
    prev_l = el;
  endtask

  function automatic logic [W-1:0] pick(input int mode);
    logic [W-1:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'hFFFF_FFFE};
    logic [W-1:0] v;
    case (mode)
      0:       v = corners[$urandom_range(0, 5)];
      1:       v = W'($signed($urandom_range(0, 200)) - 100);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic test_random();
    logic [W-1:0] a, b, eh, el, h33, l33, h, l;
    logic div, edz, dz1, dz;
    logic [35:0] bt, dt;
    for (int i = 0; i < 24; i++) begin
      a   = pick($urandom_range(0, 2));
      b   = pick($urandom_range(0, 2));
      div = 1'($urandom_range(0, 1));
      model(a, b, div, eh, el, edz);
      run_op(a, b, div, bt, dt, h33, l33, h, l, dz1, dz);
      checks++;
      if (dt !== window(33, 33) || {h33, l33} !== {prev_h, prev_l}) begin
        errors++;
        $display("FAIL rand_timing %0d: done %b hold %h/%h expected hold %h/%h",
                 i, dt, h33, l33, prev_h, prev_l);
      end
      checks++;
      if ({h, l, dz} !== {eh, el, edz}) begin
        errors++;
        $display("FAIL rand_result %0d: op=%b a=%h b=%h got %h/%h/%b expected %h/%h/%b",
                 i, div, a, b, h, l, dz, eh, el, edz);
      end
      prev_h = eh;
      prev_l = el;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_interlock();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multi-cycle multiply/divide engine and controller that owns the HI/LO register pair. It accepts MULT/DIV commands raised by the control unit's wehilo/multdiv signals, sequences a WIDTH-cycle shift-add or restoring-divide loop, and writes HI/LO on completion. It stalls the pipeline on any mfhi/mflo or new mult/div issued while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue strobe; connected to control-unit wehilo qualified by instruction valid
op_div  in  1  0 = MULT, 1 = DIV; connected to control-unit multdiv
src_a  in  WIDTH  rs operand (multiplicand or dividend), signed two's complement
src_b  in  WIDTH  rt operand (multiplier or divisor), signed two's complement
rd_hilo  in  1  mfhi or mflo issued this cycle
busy  out  1  operation in flight (state != IDLE)
stall  out  1  pipeline hold request
done  out  1  one-cycle completion pulse
div_zero  out  1  sticky divide-by-zero flag for the last DIV
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE, counter = 0, hi = 0, lo = 0, div_zero = 0, busy = 0, done = 0. Asserting reset mid-operation aborts the operation; HI/LO are cleared and nothing is written afterwards.
- States: IDLE, RUN, FINISH.
- IDLE: when start = 1 at a rising edge, latch op_div, operand magnitudes and operand signs; counter = WIDTH-1; go to RUN. When start = 0, remain in IDLE.
- RUN: perform one iteration per cycle.
  - MULT: shift-add on a 2*WIDTH accumulator.
  - DIV: restoring step; shift the remainder left, subtract the divisor magnitude, restore on borrow, shift the quotient bit in.
  - When counter = 0, go to FINISH; otherwise decrement counter.
  - Duration is exactly WIDTH cycles.
- FINISH: done = 1 for this cycle only. Apply sign correction.
  - MULT: negate the 2*WIDTH product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - At the closing edge, write hi/lo and return to IDLE.
- Latency: start is sampled at edge 0. busy is high in cycles 1..WIDTH+1, and done is high in cycle WIDTH+1. New hi/lo values are visible from cycle WIDTH+2. For the default WIDTH this is 34 edges from issue to valid HI/LO.
- stall = busy & (start | rd_hilo), and is combinational. A start seen while busy is ignored; the pipeline holds the instruction and re-presents it. hi/lo keep their old values until the FINISH edge.
- Divide by zero (src_b = 0 with op_div = 1):
  - Same latency as a normal DIV.
  - Result: hi = original dividend, lo = all ones, div_zero = 1.
  - Any subsequent accepted start clears div_zero.
- Overflow case (most-negative / -1): no special case. The result is lo = 0x80000000, hi = 0 by natural wrap.
- Magnitude arithmetic is unsigned WIDTH+1 bits internally. No X may propagate from unused accumulator bits.
- start and rd_hilo in the same cycle while IDLE: start is accepted and rd_hilo reads the current hi/lo; no stall. The pipeline orders them.

Decomposition:
- Shared package muldiv_pkg holds the following:
  - typedef enum logic [1:0] {IDLE, RUN, FINISH} md_state_t.
  - Localparams OP_MULT = 1'b0 and OP_DIV = 1'b1.
  - The DIV_ZERO_LO all-ones constant.
- The top module contains the FSM, counter, HI/LO registers, stall and sign fix.
- One sub-module, muldiv_step, is combinational. It takes the accumulator, the divisor/multiplicand magnitude and op_div, and returns the next accumulator for one iteration. This keeps the loop body separately testable.

Test Plan:
- MULT 7 × 6, start pulse at cycle 0 -> busy high cycles 1..33, done pulse at cycle 33, hi = 0x00000000, lo = 0x0000002A from cycle 34.
- MULT −3 × 5 (0xFFFFFFFD × 5) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0, lo = 1.
- DIV −17 / 5 -> lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFE (−2), div_zero = 0. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV 100 / 0 -> after 34 cycles hi = 100, lo = 0xFFFFFFFF, div_zero = 1. The next MULT start clears div_zero.
- Interlock: MULT issued, then rd_hilo = 1 at cycle 5 and a second start at cycle 10 -> stall high in both cycles and the second start is ignored. rd_hilo in cycle 34 -> stall = 0 and the new hi/lo are readable.
- Reset mid-op: DIV started, rst_n low at cycle 12 -> busy, done, hi, lo all 0 immediately. After release, no done pulse appears and a new start is accepted normally.
